mem_bus_ctrl: RTL and testbench
===============================

# mem_bus_ctrl

Memory-stage bus controller. It sits between the execute/memory pipeline boundary and the data bus. It consumes store data and byte mask already lane-aligned by the store aligner, and performs one load or store transaction at a time over a req/gnt/rvalid bus. It returns load data shifted and sign/zero-extended per RISC-V funct3, together with a completion cause (none, misaligned, bus error, timeout) for the trap logic.

## Interface
- TIMEOUT, 255: maximum cycles spent in REQ+WAIT before the transaction is abandoned; legal range 1..255.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  pipeline presents a memory op.
- req_ready  out  1  controller accepts the op; equals (state==IDLE && rst_n).
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_format  in  3  funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_wdata  in  32  store data, already lane-aligned.
- req_mask  in  4  store byte enables, already aligned.
- req_align_except  in  1  store misalignment flag from the aligner; ignored for loads.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_cause  out  2  00 ok, 01 misaligned, 10 bus error, 11 timeout.
- bus_req  out  1  bus request.
- bus_we  out  1  bus write.
- bus_addr  out  32  word address {req_addr[31:2],2'b00}.
- bus_be  out  4  byte enables (4'b0000 for loads).
- bus_wdata  out  32  write data.
- bus_gnt  in  1  request accepted.
- bus_rvalid  in  1  read data / write ack.
- bus_rdata  in  32  read data.
- bus_err  in  1  error, qualified by bus_rvalid.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: on req_valid && req_ready, register we, addr, format, wdata, mask.
  - If the op is a misaligned load (H/HU with addr[0]=1; W with addr[1:0]!=0; format 011/110/111 is treated as misaligned) or a store with req_align_except=1 → RESP with cause 01; no bus activity.
  - Otherwise → REQ.
- REQ: bus_req=1 and bus_* fields driven from the registered op. On bus_gnt → WAIT; bus_req drops the cycle after gnt.
- WAIT: on bus_rvalid → RESP. Cause is 10 if bus_err=1, else 00. Capture bus_rdata for loads.
- Timeout counter (8-bit): cleared on accept, increments each cycle in REQ or WAIT. When it equals TIMEOUT and no gnt/rvalid arrives that cycle → RESP with cause 11, and bus_req is deassigned.
- RESP: resp_valid=1 for exactly one cycle, then → IDLE. No backpressure on the response.
- Load extraction: byte = rdata lane addr[1:0]; half = lane addr[1]. Sign-extend for B/H, zero-extend for BU/HU, pass through for W.
- bus_rvalid/bus_gnt outside the state that samples them are ignored, including late responses after a timeout.
- Reset (rst_n=0 at edge): state→IDLE, counter→0. All outputs 0, including req_ready during reset. Any in-flight transaction is abandoned without a response.

## Timing
- Registered outputs: bus_*, resp_*. req_ready is combinational from state.
- Zero-wait bus (gnt in first REQ cycle, rvalid the cycle after gnt):
  - cycle 0: accept
  - cycle 1: bus_req with gnt
  - cycle 2: rvalid
  - cycle 3: resp_valid
  - Total latency 3 cycles; next accept in cycle 4.
- Misaligned op: resp_valid in cycle 1; next accept in cycle 2.
- rvalid is not sampled in the same cycle as gnt.
- Timeout fires on the cycle the counter equals TIMEOUT. resp_valid follows on the next cycle.
- Throughput: one op in flight; req_ready is 0 in REQ/WAIT/RESP.

## Test plan
- LB at addr 0x103, bus_rdata 0x80FF_0000, zero-wait → resp_rdata 0xFFFF_FF80, cause 00, resp_valid 3 cycles after accept.
- LHU at addr 0x102, bus_rdata 0xBEEF_1234 → resp_rdata 0x0000_BEEF. LW at 0x101 → cause 01 one cycle after accept, bus_req never asserted.
- SB with wdata 0x0000_AA00, mask 0010, addr 0x201; gnt delayed 3 cycles → bus_be 0010, bus_addr 0x200 held stable with bus_req until gnt. Store with req_align_except=1 → cause 01, no bus_req.
- Load with rvalid and bus_err=1 → cause 10, resp_rdata 0.
- TIMEOUT=4, gnt never asserted → cause 11 after 4 REQ cycles. bus_req low afterwards; a late gnt/rvalid in IDLE is ignored.
- rst_n low mid-WAIT → all outputs 0 and no resp_valid. After release, req_ready=1 and a new LW completes normally.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// Memory-stage bus controller: one load/store at a time over req/gnt/rvalid.
// Ports: req_* from the pipeline, resp_* to trap/writeback, and bus_* to memory.
module mem_bus_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_format,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_mask,
  input  logic        req_align_except,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_cause,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_WAIT, S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  fmt_q, fmt_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [1:0]  resp_cause_q, resp_cause_d;

  logic [8:0]  cnt_inc;
  logic        expired;
  logic        misal;

  function automatic logic load_misal(
    input logic [2:0] f,
    input logic [1:0] a
  );
    logic m;
    unique case (f)
      3'b000, 3'b100: m = 1'b0;
      3'b001, 3'b101: m = a[0];
      3'b010:         m = (a != 2'b00);
      default:        m = 1'b1;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] load_ext(
    input logic [2:0]  f,
    input logic [1:0]  a,
    input logic [31:0] d
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    unique case (a)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    unique case (f)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = d;
    endcase
    return r;
  endfunction

  assign req_ready = (state_q == S_IDLE) && rst_n;

  // Saturation is not needed: 9-bit compare also catches a gnt that
  // landed on the last allowed cycle, so WAIT cannot outlive the budget.
  assign cnt_inc = {1'b0, cnt_q} + 9'd1;
  assign expired = (cnt_inc >= 9'(TIMEOUT));

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    fmt_d        = fmt_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    cnt_d        = cnt_q;
    misal        = 1'b0;
    resp_cause_d = 2'b00;
    resp_rdata_d = 32'd0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          fmt_d   = req_format;
          wdata_d = req_wdata;
          mask_d  = req_mask;
          cnt_d   = 8'd0;
          misal   = req_we ? req_align_except
                           : load_misal(req_format, req_addr[1:0]);
          if (misal) begin
            state_d      = S_RESP;
            resp_cause_d = 2'b01;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_inc[7:0];
        if (bus_gnt) begin
          state_d = S_WAIT;
        end else if (expired) begin
          state_d      = S_RESP;
          resp_cause_d = 2'b11;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc[7:0];
        if (bus_rvalid) begin
          state_d = S_RESP;
          if (bus_err) begin
            resp_cause_d = 2'b10;
          end else if (!we_q) begin
            resp_rdata_d = load_ext(fmt_q, addr_q[1:0], bus_rdata);
          end
        end else if (expired) begin
          state_d      = S_RESP;
          resp_cause_d = 2'b11;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    bus_req_d    = (state_d == S_REQ);
    bus_we_d     = bus_req_d && we_d;
    bus_addr_d   = bus_req_d ? {addr_d[31:2], 2'b00} : 32'd0;
    bus_be_d     = bus_we_d ? mask_d : 4'd0;
    bus_wdata_d  = bus_we_d ? wdata_d : 32'd0;
    resp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      fmt_q        <= 3'd0;
      wdata_q      <= 32'd0;
      mask_q       <= 4'd0;
      cnt_q        <= 8'd0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 32'd0;
      bus_be_q     <= 4'd0;
      bus_wdata_q  <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_cause_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      fmt_q        <= fmt_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      cnt_q        <= cnt_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_be_q     <= bus_be_d;
      bus_wdata_q  <= bus_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_cause_q <= resp_cause_d;
    end
  end

  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_be     = bus_be_q;
  assign bus_wdata  = bus_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_cause = resp_cause_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed testbench for mem_bus_ctrl (TIMEOUT=4).
// Inputs driven and outputs sampled on the falling edge.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_format;
  logic [31:0] req_wdata;
  logic [3:0]  req_mask;
  logic        req_align_except;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_cause;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_bus_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_format(req_format), .req_wdata(req_wdata),
    .req_mask(req_mask), .req_align_except(req_align_except),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_cause(resp_cause),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  // Drives one op for a single cycle; returns on the first
  // falling edge after the accepting rising edge.
  task automatic issue(input logic we, input logic [31:0] a,
                       input logic [2:0] f, input logic [31:0] wd,
                       input logic [3:0] m, input logic ae);
    req_valid = 1'b1;
    req_we = we; req_addr = a; req_format = f;
    req_wdata = wd; req_mask = m; req_align_except = ae;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ready: got %b want 0", req_ready);
    end
    n_checks++;
    if ({bus_req, resp_valid, bus_addr, resp_cause} !== 36'd0) begin
      n_fail++;
      $display("FAIL rst_outs: bus_req=%b resp_valid=%b addr=%h",
               bus_req, resp_valid, bus_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_release_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_lb_zero_wait;
    issue(1'b0, 32'h103, 3'b000, 32'd0, 4'd0, 1'b0);
    n_checks++;
    if ({bus_req, bus_we, bus_addr, bus_be} !== {2'b10, 32'h100, 4'h0}) begin
      n_fail++;
      $display("FAIL lb_bus: req=%b we=%b addr=%h be=%b",
               bus_req, bus_we, bus_addr, bus_be);
    end
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    n_checks++;
    if (bus_req !== 1'b0) begin
      n_fail++;
      $display("FAIL lb_req_drop: got %b want 0", bus_req);
    end
    bus_rvalid = 1'b1; bus_rdata = 32'h80FF_0000; bus_err = 1'b0;
    @(negedge clk);
    bus_rvalid = 1'b0;
    n_checks++;
    if ({resp_valid, resp_cause, resp_rdata} !== {3'b100, 32'hFFFF_FF80}) begin
      n_fail++;
      $display("FAIL lb_resp: valid=%b cause=%b rdata=%h want 1 00 ffffff80",
               resp_valid, resp_cause, resp_rdata);
    end
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL lb_ready_in_resp: got %b want 0", req_ready);
    end
    @(negedge clk);
    n_checks++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL lb_after: valid=%b ready=%b want 0 1",
               resp_valid, req_ready);
    end
  endtask

  task automatic test_formats;
    logic [2:0]  fmt [5];
    logic [31:0] adr [5];
    logic [31:0] rd  [5];
    logic [31:0] exp [5];
    fmt[0] = 3'b101; adr[0] = 32'h102; rd[0] = 32'hBEEF_1234;
    exp[0] = 32'h0000_BEEF;
    fmt[1] = 3'b001; adr[1] = 32'h002; rd[1] = 32'h8001_7FFF;
    exp[1] = 32'hFFFF_8001;
    fmt[2] = 3'b001; adr[2] = 32'h000; rd[2] = 32'h8001_7FFF;
    exp[2] = 32'h0000_7FFF;
    fmt[3] = 3'b100; adr[3] = 32'h001; rd[3] = 32'h0000_9A00;
    exp[3] = 32'h0000_009A;
    fmt[4] = 3'b010; adr[4] = 32'h004; rd[4] = 32'hCAFE_F00D;
    exp[4] = 32'hCAFE_F00D;
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, adr[i], fmt[i], 32'd0, 4'd0, 1'b0);
      bus_gnt = 1'b1;
      @(negedge clk);
      bus_gnt = 1'b0;
      bus_rvalid = 1'b1; bus_rdata = rd[i]; bus_err = 1'b0;
      @(negedge clk);
      bus_rvalid = 1'b0;
      n_checks++;
      if ({resp_valid, resp_cause, resp_rdata} !== {3'b100, exp[i]}) begin
        n_fail++;
        $display("FAIL fmt%0d: valid=%b cause=%b rdata=%h want 1 00 %h",
                 i, resp_valid, resp_cause, resp_rdata, exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_misaligned;
    logic seen;
    issue(1'b0, 32'h101, 3'b010, 32'd0, 4'd0, 1'b0);
    seen = bus_req;
    n_checks++;
    if ({resp_valid, resp_cause, resp_rdata} !== {3'b101, 32'd0}) begin
      n_fail++;
      $display("FAIL lw_mis_resp: valid=%b cause=%b rdata=%h want 1 01 0",
               resp_valid, resp_cause, resp_rdata);
    end
    @(negedge clk);
    seen = seen | bus_req;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL lw_mis_ready: got %b want 1", req_ready);
    end
    issue(1'b1, 32'h202, 3'b010, 32'h1234_5678, 4'hF, 1'b1);
    seen = seen | bus_req;
    n_checks++;
    if ({resp_valid, resp_cause} !== 3'b101) begin
      n_fail++;
      $display("FAIL st_mis_resp: valid=%b cause=%b want 1 01",
               resp_valid, resp_cause);
    end
    @(negedge clk);
    seen = seen | bus_req;
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_no_bus: bus_req seen=%b want 0", seen);
    end
  endtask

  task automatic test_store_delayed_gnt;
    int bad;
    bad = 0;
    issue(1'b1, 32'h201, 3'b000, 32'h0000_AA00, 4'b0010, 1'b0);
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata} !==
          {2'b11, 32'h200, 4'b0010, 32'h0000_AA00}) begin
        n_fail++;
        $display("FAIL sb_hold c%0d: req=%b we=%b addr=%h be=%b wd=%h",
                 c, bus_req, bus_we, bus_addr, bus_be, bus_wdata);
      end
      if (c == 3) bus_gnt = 1'b1;
      @(negedge clk);
    end
    bus_gnt = 1'b0;
    n_checks++;
    if (bus_req !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_req_drop: got %b want 0", bus_req);
    end
    bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF; bus_err = 1'b0;
    @(negedge clk);
    bus_rvalid = 1'b0;
    n_checks++;
    if ({resp_valid, resp_cause, resp_rdata} !== {3'b100, 32'd0}) begin
      n_fail++;
      $display("FAIL sb_resp: valid=%b cause=%b rdata=%h want 1 00 0",
               resp_valid, resp_cause, resp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_bus_err;
    issue(1'b0, 32'h300, 3'b010, 32'd0, 4'd0, 1'b0);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678; bus_err = 1'b1;
    @(negedge clk);
    bus_rvalid = 1'b0; bus_err = 1'b0;
    n_checks++;
    if ({resp_valid, resp_cause, resp_rdata} !== {3'b110, 32'd0}) begin
      n_fail++;
      $display("FAIL err_resp: valid=%b cause=%b rdata=%h want 1 10 0",
               resp_valid, resp_cause, resp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int reqs;
    reqs = 0;
    issue(1'b0, 32'h400, 3'b010, 32'd0, 4'd0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      if (bus_req === 1'b1) reqs++;
      n_checks++;
      if (resp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL to_early c%0d: resp_valid=%b want 0", c, resp_valid);
      end
      @(negedge clk);
    end
    n_checks++;
    if (reqs != 4) begin
      n_fail++;
      $display("FAIL to_req_cycles: got %0d want 4", reqs);
    end
    n_checks++;
    if ({resp_valid, resp_cause, bus_req} !== 4'b1110) begin
      n_fail++;
      $display("FAIL to_resp: valid=%b cause=%b bus_req=%b want 1 11 0",
               resp_valid, resp_cause, bus_req);
    end
    @(negedge clk);
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h5555_AAAA;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if ({resp_valid, bus_req, req_ready} !== 3'b001) begin
        n_fail++;
        $display("FAIL to_late c%0d: valid=%b bus_req=%b ready=%b",
                 c, resp_valid, bus_req, req_ready);
      end
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
  endtask

  task automatic test_reset_mid_wait;
    int pulses;
    pulses = 0;
    issue(1'b0, 32'h500, 3'b010, 32'd0, 4'd0, 1'b0);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({req_ready, bus_req, resp_valid, resp_cause, resp_rdata} !== 36'd0)
    begin
      n_fail++;
      $display("FAIL midrst_outs: ready=%b req=%b valid=%b cause=%b rd=%h",
               req_ready, bus_req, resp_valid, resp_cause, resp_rdata);
    end
    bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    if (resp_valid) pulses++;
    bus_rvalid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    if (resp_valid) pulses++;
    n_checks++;
    if (pulses != 0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_release: pulses=%0d ready=%b want 0 1",
               pulses, req_ready);
    end
    issue(1'b0, 32'h600, 3'b010, 32'd0, 4'd0, 1'b0);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D; bus_err = 1'b0;
    @(negedge clk);
    bus_rvalid = 1'b0;
    n_checks++;
    if ({resp_valid, resp_cause, resp_rdata} !== {3'b100, 32'hCAFE_F00D}) begin
      n_fail++;
      $display("FAIL midrst_lw: valid=%b cause=%b rdata=%h want 1 00 cafef00d",
               resp_valid, resp_cause, resp_rdata);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
    req_format = 3'd0; req_wdata = 32'd0; req_mask = 4'd0;
    req_align_except = 1'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0; bus_err = 1'b0;
    @(negedge clk);
    test_reset;
    test_lb_zero_wait;
    test_formats;
    test_misaligned;
    test_store_delayed_gnt;
    test_bus_err;
    test_timeout;
    test_reset_mid_wait;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
